// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and constants for the round-robin mux arbiter
// Optional feature macro used by importers: MUX_ARB_TIMEOUT_EN
package mux_arb_pkg;

    localparam int N_SRC = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_SRC-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return N_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin winner search over 8 requests
// Ports:
//   req_mask_i [7:0] : candidate requests
//   ptr_i      [2:0] : last granted index; search starts at ptr_i+1
//   idx_o      [2:0] : first set request in search order
//   found_o          : any bit of req_mask_i set
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [N_SRC-1:0] req_mask_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [IDX_W-1:0] cand;

    // Offsets 1..8 visit every index once, ending on ptr_i itself; the 3-bit
    // add wraps modulo 8 naturally.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            cand = ptr_i + IDX_W'(i);
            if (!found_o && req_mask_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_arb_sched.sv
// rtl/mux_arb_sched.sv - round-robin arbitrated 8:1 bit mux with optional hold timeout
// Optional feature macro: MUX_ARB_TIMEOUT_EN (hold counter limited by HOLD_MAX)
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req  [7:0] : per-source request, held until served, dropped to release
//   in   [7:0] : per-source data bit
//   gnt  [7:0] : registered one-hot grant
//   sel  [2:0] : registered owner index
//   y          : in[sel] while busy, else 0
//   busy       : high while in GRANT
module mux_arb_sched
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] in,
    output logic [N_SRC-1:0] gnt,
    output logic [IDX_W-1:0] sel,
    output logic             y,
    output logic             busy
);

    if (HOLD_MAX < 1) begin : g_bad_hold_max
        $error("HOLD_MAX must be at least 1");
    end

    state_e           state_q, state_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [N_SRC-1:0] pick_mask;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             hold_expired;

    // While granted the owner is masked out: if it released, its bit is 0
    // anyway; if it is being pre-empted, it must not win again.
    assign pick_mask = (state_q == GRANT) ? (req & ~gnt_q) : req;

    rr_pick8 u_pick (
        .req_mask_i (pick_mask),
        .ptr_i      (ptr_q),
        .idx_o      (pick_idx),
        .found_o    (pick_found)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign hold_expired = (cnt_q == HOLD_LIMIT);

    // Cleared on every new grant, counts each held GRANT cycle, saturates at
    // the limit so a lone owner keeps the bus.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == GRANT && gnt_d != gnt_q) begin
            cnt_d = '0;
        end else if (state_q == GRANT && !hold_expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = idx2onehot(pick_idx);
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx;
                end
            end
            GRANT: begin
                if (!req[sel_q] || hold_expired) begin
                    if (pick_found) begin
                        gnt_d = idx2onehot(pick_idx);
                        sel_d = pick_idx;
                        ptr_d = pick_idx;
                    end else if (!req[sel_q]) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= IDX_W'(N_SRC - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == GRANT);

    always_comb begin
        y = 1'b0;
        if (busy) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (sel_q == IDX_W'(i)) begin
                    y = in[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_sched.sv
// tb/tb_mux_arb_sched.sv - self-checking bench for mux_arb_sched (honours MUX_ARB_TIMEOUT_EN)
module tb_mux_arb_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] in;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       y;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    mux_arb_sched #(.HOLD_MAX(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .in   (in),
        .gnt  (gnt),
        .sel  (sel),
        .y    (y),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       y;
        string      name;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] in;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       y;
        string      name;
    } vec_t;

    exp_t sb[$];

    task automatic check_field(input string name, input string field, input int act, input int req_v);
        n_cmp++;
        if (act != req_v) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%0h, required 0x%0h", name, field, act, req_v);
        end
    endtask

    // Drive one cycle of stimulus away from the edge, queue its expected
    // outcome, then compare just after the edge that registers it.
    task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] d,
                        input logic [7:0] eg, input logic [2:0] es, input logic eb,
                        input logic ey, input string name);
        exp_t e;
        rst = r;
        req = rq;
        in  = d;
        e.gnt = eg; e.sel = es; e.busy = eb; e.y = ey; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.scoreboard: queue empty, required 1 entry", name);
        end else begin
            e = sb.pop_front();
            check_field(e.name, "gnt",  int'(gnt),  int'(e.gnt));
            check_field(e.name, "sel",  int'(sel),  int'(e.sel));
            check_field(e.name, "busy", int'(busy), int'(e.busy));
            check_field(e.name, "y",    int'(y),    int'(e.y));
        end
    endtask

    vec_t vecs[10];

    initial begin
        logic [7:0] eg;
        int         nxt;

        vecs[0] = '{1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "reset"};
        vecs[1] = '{1'b0, 8'h01, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1, "first_grant"};
        vecs[2] = '{1'b0, 8'h01, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0, "hold_y0"};
        vecs[3] = '{1'b0, 8'h03, 8'h02, 8'h01, 3'd0, 1'b1, 1'b0, "nonowner_ignored"};
        vecs[4] = '{1'b0, 8'h02, 8'h02, 8'h02, 3'd1, 1'b1, 1'b1, "handoff_no_bubble"};
        vecs[5] = '{1'b0, 8'h00, 8'hFF, 8'h00, 3'd1, 1'b0, 1'b0, "release_idle"};
        vecs[6] = '{1'b0, 8'h00, 8'hFF, 8'h00, 3'd1, 1'b0, 1'b0, "idle_stays"};
        vecs[7] = '{1'b0, 8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1, "rr_from_ptr1"};
        vecs[8] = '{1'b0, 8'h01, 8'h80, 8'h01, 3'd0, 1'b1, 1'b0, "wrap_to_0"};
        vecs[9] = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "idle_again"};

        rst = 1'b1; req = '0; in = '0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].in, vecs[i].gnt, vecs[i].sel,
                 vecs[i].busy, vecs[i].y, vecs[i].name);
        end

        // Full round robin: owner drops each cycle, everyone else keeps asking.
        step(1'b1, 8'h00, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b0, "rr_reset");
        step(1'b0, 8'hFF, 8'hAA, 8'h01, 3'd0, 1'b1, 1'b0, "rr_start");
        for (int k = 0; k < 8; k++) begin
            nxt = (k + 1) % 8;
            eg  = 8'h01 << nxt;
            step(1'b0, 8'hFF & ~(8'h01 << k), 8'hAA, eg, 3'(nxt), 1'b1,
                 (8'hAA >> nxt) & 1'b1 ? 1'b1 : 1'b0, $sformatf("rr_%0d", nxt));
        end

        // Owner 3 alone releases: straight to IDLE.
        step(1'b1, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, "drop_reset");
        step(1'b0, 8'h08, 8'hFF, 8'h08, 3'd3, 1'b1, 1'b1, "drop_grant3");
        step(1'b0, 8'h00, 8'hFF, 8'h00, 3'd3, 1'b0, 1'b0, "drop_idle");

        // Hold timeout (or indefinite hold without the macro).
        step(1'b1, 8'h00, 8'h24, 8'h00, 3'd0, 1'b0, 1'b0, "to_reset");
        step(1'b0, 8'h04, 8'h24, 8'h04, 3'd2, 1'b1, 1'b1, "to_grant2");
        for (int e = 2; e <= 8; e++) begin
`ifdef MUX_ARB_TIMEOUT_EN
            if (e >= 5)
                step(1'b0, 8'h24, 8'h24, 8'h20, 3'd5, 1'b1, 1'b1, $sformatf("to_cyc%0d", e));
            else
                step(1'b0, 8'h24, 8'h24, 8'h04, 3'd2, 1'b1, 1'b1, $sformatf("to_cyc%0d", e));
`else
            step(1'b0, 8'h24, 8'h24, 8'h04, 3'd2, 1'b1, 1'b1, $sformatf("to_cyc%0d", e));
`endif
        end

        // Lone owner never loses the grant (counter saturates).
        step(1'b1, 8'h00, 8'h04, 8'h00, 3'd0, 1'b0, 1'b0, "sat_reset");
        for (int e = 1; e <= 8; e++) begin
            step(1'b0, 8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1, $sformatf("sat_cyc%0d", e));
        end

        // Reset mid-grant, grants blocked during reset, search restarts at 0.
        step(1'b1, 8'h00, 8'h40, 8'h00, 3'd0, 1'b0, 1'b0, "mr_reset");
        step(1'b0, 8'h40, 8'h40, 8'h40, 3'd6, 1'b1, 1'b1, "mr_grant6");
        step(1'b1, 8'h40, 8'h40, 8'h00, 3'd0, 1'b0, 1'b0, "mr_rst_midgrant");
        step(1'b1, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, "mr_rst_blocks");
        step(1'b0, 8'hC0, 8'h40, 8'h40, 3'd6, 1'b1, 1'b1, "mr_regrant6");

        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
